// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared frame-config type, parity codes and arbiter state encoding
package uart_tx_arbiter_pkg;

    typedef struct packed {
        logic       d_num;
        logic       s_num;
        logic [1:0] par;
    } frame_cfg_t;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GUARD
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rtl/uart_tx_arbiter_rr_arbiter.sv - combinational round-robin picker, first request after i_ptr wins
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = |i_req;
        // Scan farthest-first so the nearest request after i_ptr is the last to be written.
        for (int k = N; k >= 1; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_gnt = N'(1) << ((int'(i_ptr) + k) % N);
                o_idx = W'((int'(i_ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of one UART TX; optional frame timeout via UART_ARB_TIMEOUT_EN
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int OW = $clog2(NUM_REQ)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ*8-1:0] i_req_data,
    input  logic [NUM_REQ*4-1:0] i_req_cfg,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [NUM_REQ-1:0]   o_done,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    output logic                 o_tx_d_num,
    output logic                 o_tx_s_num,
    output logic [1:0]           o_tx_par,
    input  logic                 i_tx_busy,
    input  logic                 i_tx_done,
    output logic [OW-1:0]        o_owner,
    output logic                 o_busy,
    output logic                 o_timeout_err,
    input  logic                 i_err_clr
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    arb_state_t           r_state;
    logic [OW-1:0]        r_rr_ptr;
    logic [OW-1:0]        r_owner;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    frame_cfg_t           r_tx_cfg;
    logic                 r_busy;
    logic [GW-1:0]        r_guard_cnt;

    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [OW-1:0]        w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_waiting;
    logic                 w_complete;
    logic                 w_timeout;
    frame_cfg_t           w_pick_cfg;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .i_req   (i_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_pick_cfg = i_req_cfg[int'(w_pick_idx)*4 +: 4];
    assign w_waiting  = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
    assign w_complete = w_waiting && i_tx_done;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;

    // Fires on the TIMEOUT_CYCLES-th waiting cycle that has no tx_done.
    assign w_timeout = w_waiting && !i_tx_done && (r_to_cnt == TO_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_START)
                r_to_cnt <= '0;
            else if (w_waiting)
                r_to_cnt <= r_to_cnt + TW'(1);
            if (i_err_clr)
                r_timeout_err <= 1'b0;
            else if (w_timeout)
                r_timeout_err <= 1'b1;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    logic w_unused_err_clr;

    assign w_timeout        = 1'b0;
    assign w_unused_err_clr = i_err_clr ^ (TIMEOUT_CYCLES == 0);
    assign o_timeout_err    = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= OW'(NUM_REQ - 1);
            r_owner     <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_tx_cfg    <= '0;
            r_busy      <= 1'b0;
            r_guard_cnt <= '0;
        end else begin
            r_gnt      <= '0;
            r_done     <= '0;
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid && !i_tx_busy) begin
                        r_owner    <= w_pick_idx;
                        r_tx_data  <= i_req_data[int'(w_pick_idx)*8 +: 8];
                        r_tx_cfg   <= w_pick_cfg;
                        r_gnt      <= w_pick_gnt;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    if (w_complete || w_timeout) begin
                        r_done   <= NUM_REQ'(1) << r_owner;
                        r_rr_ptr <= r_owner;
                        if (GUARD_CYCLES == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_guard_cnt <= GUARD_LOAD;
                            r_state     <= ST_GUARD;
                        end
                    end else if (r_state == ST_WAIT_BUSY && i_tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_GUARD: begin
                    if (r_guard_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_guard_cnt <= r_guard_cnt - GW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt      = r_gnt;
    assign o_done     = r_done;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_tx_d_num = r_tx_cfg.d_num;
    assign o_tx_s_num = r_tx_cfg.s_num;
    assign o_tx_par   = r_tx_cfg.par;
    assign o_owner    = r_owner;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - cycle-checked bench for uart_tx_arbiter with a frame-level reference model
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int G  = 2;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N*4-1:0] req_cfg = '0;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic           err_clr = 1'b0;

    logic [N-1:0]   gnt, done;
    logic           tx_start, tx_d_num, tx_s_num, busy, timeout_err;
    logic [7:0]     tx_data;
    logic [1:0]     tx_par;
    logic [1:0]     owner;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_req(req), .i_req_data(req_data), .i_req_cfg(req_cfg),
        .o_gnt(gnt), .o_done(done), .o_tx_start(tx_start), .o_tx_data(tx_data),
        .o_tx_d_num(tx_d_num), .o_tx_s_num(tx_s_num), .o_tx_par(tx_par),
        .i_tx_busy(tx_busy), .i_tx_done(tx_done), .o_owner(owner), .o_busy(busy),
        .o_timeout_err(timeout_err), .i_err_clr(err_clr)
    );

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: one frame record plus the cycle numbers at which things must happen.
    bit         m_active = 0;
    int         m_gnt_cyc = -10, m_done_cyc = -10, m_idle_from = 0;
    int         m_owner = 0, m_done_owner = 0, m_last = N - 1;
    logic [7:0] m_data = '0;
    logic [3:0] m_cfg = '0;
    bit         m_err = 0;

    function automatic int pick(input logic [N-1:0] r, input int after);
        for (int k = 1; k <= N; k++) begin
            if (r[(after + k) % N]) return (after + k) % N;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] sr;
        logic sb, sd, srst, sclr;
        bit fin, to_hit;
        int w;
        sr = req; sb = tx_busy; sd = tx_done; srst = rst; sclr = err_clr;
        fin = 0; to_hit = 0;
        cyc++;
        if (srst) begin
            m_active = 0; m_last = N - 1; m_owner = 0; m_data = '0; m_cfg = '0;
            m_done_cyc = -10; m_idle_from = 0; m_err = 0;
        end else begin
            if (m_active && cyc - 1 > m_gnt_cyc) begin
                if (sd) fin = 1;
`ifdef UART_ARB_TIMEOUT_EN
                else if (cyc - 1 - m_gnt_cyc == TO) begin fin = 1; to_hit = 1; end
`endif
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (sclr) m_err = 0;
            else if (to_hit) m_err = 1;
`endif
            if (fin) begin
                m_active = 0; m_done_cyc = cyc; m_done_owner = m_owner;
                m_last = m_owner; m_idle_from = cyc + G;
            end else if (!m_active && cyc - 1 >= m_idle_from && !sb && sr != 0) begin
                w = pick(sr, m_last);
                m_active = 1; m_gnt_cyc = cyc; m_owner = w;
                m_data = req_data[w*8 +: 8]; m_cfg = req_cfg[w*4 +: 4];
            end
        end
        #1;
        chk("gnt", 32'(gnt), (m_active && cyc == m_gnt_cyc) ? 32'(1) << m_owner : 32'd0);
        chk("tx_start", 32'(tx_start), (m_active && cyc == m_gnt_cyc) ? 32'd1 : 32'd0);
        chk("done", 32'(done), (cyc == m_done_cyc) ? 32'(1) << m_done_owner : 32'd0);
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("tx_d_num", 32'(tx_d_num), 32'(m_cfg[3]));
        chk("tx_s_num", 32'(tx_s_num), 32'(m_cfg[2]));
        chk("tx_par", 32'(tx_par), 32'(m_cfg[1:0]));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy", 32'(busy), (m_active || cyc < m_idle_from) ? 32'd1 : 32'd0);
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
    end

    // Simple transmitter stand-in: busy after tx_start, done pulse xlen cycles later.
    bit xmit_en = 0;
    int xcnt = 0, xlen = 10, xdone_cyc = -1;

    always @(negedge clk) begin
        if (xmit_en && !rst) begin
            tx_done = 1'b0;
            if (xcnt > 0) begin
                xcnt--;
                if (xcnt == 0) begin tx_done = 1'b1; tx_busy = 1'b0; xdone_cyc = cyc; end
            end else if (tx_start) begin
                tx_busy = 1'b1; xcnt = xlen;
            end
        end
    end

    task automatic wait_start();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (tx_start) ok = 1;
        end
        chk("start_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (done != 0) ok = 1;
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        chk("idle_seen", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; tx_busy = 1'b0; tx_done = 1'b0; xcnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int s, d, prev_d, ng;
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, prev_d, ng;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;

        // 1: single requester
        xmit_en = 1; xlen = 5;
        req_data[7:0] = 8'hA5; req_cfg[3:0] = 4'b1001; req = 4'b0001;
        wait_start();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_data", 32'(tx_data), 32'hA5);
        chk("t1_par", 32'(tx_par), 32'h1);
        chk("t1_dnum", 32'(tx_d_num), 32'h1);
        chk("t1_snum", 32'(tx_s_num), 32'h0);
        req = '0;
        wait_done();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_done_lat", 32'(cyc - xdone_cyc), 32'd1);

        // 2: all four held, fairness and guard gap
        do_reset();
        xlen = 10;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_cfg  = {4'b0001, 4'b0010, 4'b1100, 4'b0011};
        req = 4'b1111;
        prev_d = 0;
        for (int k = 0; k < 5; k++) begin
            wait_start();
            s = cyc;
            chk("t2_order", 32'(idx_of(gnt)), 32'(k % 4));
            chk("t2_data", 32'(tx_data), 32'h10 + 32'(k % 4));
            if (k > 0) chk("t2_gap", 32'(s - prev_d - 1), 32'(G));
            wait_done();
            prev_d = cyc;
        end
        req = '0;
        wait_idle();

        // 3: request data/config changed after gnt
        req_data[15:8] = 8'h3C; req_cfg[7:4] = 4'b0110; req = 4'b0010;
        wait_start();
        chk("t3_gnt", 32'(gnt), 32'h2);
        req_data[15:8] = 8'hC3; req_cfg[7:4] = 4'b1011;
        repeat (3) @(negedge clk);
        chk("t3_hold_data", 32'(tx_data), 32'h3C);
        chk("t3_hold_par", 32'(tx_par), 32'h2);
        chk("t3_hold_snum", 32'(tx_s_num), 32'h1);
        wait_start();
        chk("t3_new_data", 32'(tx_data), 32'hC3);
        chk("t3_new_par", 32'(tx_par), 32'h3);
        chk("t3_new_dnum", 32'(tx_d_num), 32'h1);
        req = '0;
        wait_done();
        wait_idle();

        // 4: transmitter still busy, stray tx_done in IDLE
        xmit_en = 0;
        @(negedge clk);
        tx_busy = 1'b1; req_data[23:16] = 8'h5A; req_cfg[11:8] = 4'b0101; req = 4'b0100;
        ng = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_done = (i == 2);
            if (gnt != 0 || done != 0) ng++;
        end
        tx_done = 1'b0;
        chk("t4_no_gnt_done", 32'(ng), 32'd0);
        tx_busy = 1'b0;
        wait_start();
        chk("t4_gnt", 32'(gnt), 32'h4);
        req = '0;
        @(negedge clk) tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        tx_done = 1'b1; tx_busy = 1'b0;
        @(negedge clk) tx_done = 1'b0;
        chk("t4_done", 32'(done), 32'h4);
        wait_idle();

        // 5: reset in WAIT_DONE
        req_data[31:24] = 8'hE7; req_cfg[15:12] = 4'b1110; req = 4'b1010;
        wait_start();
        chk("t5_gnt", 32'(gnt), 32'h8);
        req = 4'b1001;
        @(negedge clk) tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_rst_data", 32'(tx_data), 32'h0);
        chk("t5_rst_cfg", 32'({tx_d_num, tx_s_num, tx_par}), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_owner", 32'(owner), 32'h0);
        chk("t5_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        tx_busy = 1'b0; xcnt = 0; xmit_en = 1; xlen = 4;
        rst = 1'b0;
        wait_start();
        chk("t5_restart_gnt", 32'(gnt), 32'h1);
        req = '0;
        wait_done();
        wait_idle();

`ifdef UART_ARB_TIMEOUT_EN
        // 6: hung transmitter
        do_reset();
        xmit_en = 0;
        req = 4'b0011;
        wait_start();
        s = cyc;
        chk("t6_gnt", 32'(gnt), 32'h1);
        req = 4'b0010;
        wait_done();
        d = cyc;
        chk("t6_to_cycle", 32'(d - s), 32'(TO + 1));
        chk("t6_done", 32'(done), 32'h1);
        chk("t6_err", 32'(timeout_err), 32'h1);
        err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("t6_err_clr", 32'(timeout_err), 32'h0);
        wait_start();
        chk("t6_next_gnt", 32'(gnt), 32'h2);
        req = '0;
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ requesters.
- Captures the winning requester's byte and frame configuration (d_num, s_num, par), then issues a single start to the transmitter.
- Tracks the frame to completion and returns per-requester grant and done pulses.
- Sits between client logic (command/status engines) and the UART TX datapath, which uses the same frame-config encoding as the UART receiver.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GUARD_CYCLES, 2, idle clk cycles forced between frames (0 = none)
TIMEOUT_CYCLES, 65535, max clk cycles from tx_start to tx_done (used only with UART_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all I/O synchronous to it
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester frame request, level
req_data  in  NUM_REQ*8  byte for requester i at [8i+7:8i]
req_cfg  in  NUM_REQ*4  {d_num, s_num, par[1:0]} for requester i at [4i+3:4i]
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: data/cfg captured
done  out  NUM_REQ  one-hot, 1-cycle pulse: frame finished
tx_start  out  1  1-cycle start strobe to transmitter
tx_data  out  8  captured byte, stable from tx_start until back in IDLE
tx_d_num, tx_s_num  out  1 each  captured data-length / stop-count select
tx_par  out  2  captured parity mode (00/11 none, 01 odd, 10 even)
tx_busy  in  1  transmitter frame in progress
tx_done  in  1  transmitter 1-cycle completion pulse
owner  out  $clog2(NUM_REQ)  index of current/last owner
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset: state=IDLE, rr_ptr=NUM_REQ-1, all outputs 0 (gnt, done, tx_start, tx_data, tx_d_num, tx_s_num, tx_par, owner, busy, timeout_err).
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD.
- IDLE:
  - If |req and !tx_busy: the winner is the first set req scanning from rr_ptr+1 upward, with wrap-around.
  - Register owner, tx_data, tx_d_num, tx_s_num and tx_par from the winner's slices; pulse gnt[winner] next cycle; go to START.
  - If tx_busy=1 (transmitter still draining), stay in IDLE.
- START: tx_start=1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1: go to WAIT_DONE.
  - tx_done=1 (possibly in the same cycle as tx_busy): treat as completion.
- WAIT_DONE: on tx_done, pulse done[owner] next cycle, set rr_ptr=owner, then go to GUARD, or to IDLE if GUARD_CYCLES=0.
- GUARD: down-counter loaded with GUARD_CYCLES; go to IDLE when it reaches 0. Requests are ignored in GUARD.
- Request rules:
  - The requester holds req, req_data and req_cfg stable until it sees gnt; after gnt it may change them.
  - A req still high after gnt is a new frame; it competes in the next arbitration.
  - A req that drops before gnt is withdrawn, with no side effects.
- Grant-to-start latency: gnt and tx_start are driven in the same cycle (the first START cycle), one cycle after the IDLE sample.
- Fairness: with all requests held high, grants rotate 0,1,2,3,0... No requester waits more than NUM_REQ-1 frames.
- Config stability: captured tx_* values never change between tx_start and the return to IDLE, even if req_cfg changes.
- tx_done seen in IDLE, START or GUARD is ignored (stray pulse).
- Reset mid-frame returns to IDLE immediately. The transmitter is reset independently; no done is issued.
- err_clr has priority over a simultaneous timeout set.

Optional Feature:
UART_ARB_TIMEOUT_EN:
- Defined:
  - A counter is cleared in START and increments in WAIT_BUSY/WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without tx_done: set timeout_err, pulse done[owner], go to GUARD.
  - rr_ptr=owner, so a hung frame cannot starve the other requesters.
- Undefined: no counter; the block waits indefinitely for tx_done; timeout_err is tied 0 and err_clr is unused.

Decomposition:
- Shared package (defs) holds:
  - the frame-config typedef struct {d_num, s_num, par[1:0]};
  - parity-mode constants PAR_NONE0=00, PAR_ODD=01, PAR_EVEN=10, PAR_NONE3=11;
  - a state enum for this block.
- One sub-module, rr_arbiter: combinational round-robin picker; inputs req and rr_ptr, outputs one-hot grant and its index. Reusable by the RX-side buffer.

Test Plan:
1. Single requester: req=0001, data 0xA5, cfg 4'b1001 -> gnt=0001 and tx_start in the same cycle; tx_data=0xA5, tx_par=01, tx_d_num=1, tx_s_num=0; done=0001 one cycle after tx_done.
2. All four held high, with tx_done 10 cycles after tx_start -> grant order 0,1,2,3,0; exactly GUARD_CYCLES=2 idle cycles between done and the next tx_start.
3. req_cfg and req_data changed mid-frame after gnt -> tx_* outputs unchanged until IDLE; the next frame uses the new values.
4. tx_busy held high at request time -> no gnt until tx_busy=0; stray tx_done in IDLE -> no done pulse.
5. Reset asserted in WAIT_DONE -> all outputs 0 in the same cycle; no done; the next arbitration starts from requester 0.
6. UART_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=20 and tx_done never sent -> done[owner] and timeout_err=1 at cycle 20; err_clr -> timeout_err=0; the next requester is granted.
